// File: rtl/rf_2p_23x64_fifo_ctrl_pkg.sv
// Shared constants for the 23x64 two-port RF FIFO controller: RF geometry,
// active-low enable encoding and the producer identifiers used by the arbiter.
package rf_2p_23x64_fifo_ctrl_pkg;

    localparam int unsigned RfDataWidth = 23;
    localparam int unsigned RfAddrWidth = 6;
    localparam int unsigned RfDepth     = 1 << RfAddrWidth;

    // RF chip/write enables are active low.
    localparam logic RfEnActive = 1'b0;
    localparam logic RfEnIdle   = 1'b1;

    typedef enum logic {
        Prod0 = 1'b0,
        Prod1 = 1'b1
    } prod_e;

    function automatic logic rf_en(input logic active);
        return active ? RfEnActive : RfEnIdle;
    endfunction

endpackage

// File: rtl/rf_fifo_skid2.sv
// Two-entry output skid buffer that absorbs the RF's one-cycle read latency.
// clr empties the buffer synchronously and takes priority over push and pop.
module rf_fifo_skid2 #(
    parameter int unsigned Width = 23
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [1:0]       cnt
);

    logic [Width-1:0] mem_q [2];
    logic             wr_idx_q;
    logic             rd_idx_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (clr) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q] <= push_dat;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem_q[rd_idx_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rf_2p_23x64_fifo_ctrl.sv
// FIFO controller for the 23x64 two-port RF: arbitrates two producers onto port B,
// prefetches through port A into a 2-entry skid. RF_FIFO_FIXED_PRIO_EN selects fixed priority.
module rf_2p_23x64_fifo_ctrl
    import rf_2p_23x64_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RfDataWidth,
    parameter int unsigned ADDR_WIDTH = RfAddrWidth
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    input  logic                  wr0_val_i,
    input  logic [DATA_WIDTH-1:0] wr0_dat_i,
    input  logic                  wr1_val_i,
    input  logic [DATA_WIDTH-1:0] wr1_dat_i,
    output logic                  wr0_rdy_o,
    output logic                  wr1_rdy_o,
    output logic                  rd_val_o,
    output logic [DATA_WIDTH-1:0] rd_dat_o,
    input  logic                  rd_rdy_i,
    output logic [ADDR_WIDTH:0]   cnt_o,
    output logic                  rf_cena_o,
    output logic [ADDR_WIDTH-1:0] rf_addra_o,
    input  logic [DATA_WIDTH-1:0] rf_dataa_i,
    output logic                  rf_cenb_o,
    output logic                  rf_wenb_o,
    output logic [ADDR_WIDTH-1:0] rf_addrb_o,
    output logic [DATA_WIDTH-1:0] rf_datab_o
);

    localparam logic [ADDR_WIDTH:0] FullCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   rf_cnt_q, rf_cnt_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  pend_q, pend_d;

    logic [1:0] skid_cnt;
    logic [2:0] skid_cnt_nxt;
    logic [2:0] inflight;
    prod_e      pick;
    logic       pick_val;
    logic       full;
    logic       wr_fire;
    logic       rd_issue;
    logic       pop;
    logic       skid_push;

    // Arbitration: grant is presented even with no valid so an idle producer sees rdy.
`ifdef RF_FIFO_FIXED_PRIO_EN
    always_comb begin
        pick = (wr0_val_i || !wr1_val_i) ? Prod0 : Prod1;
    end
`else
    prod_e rr_q, rr_d;

    always_comb begin
        if (wr0_val_i == wr1_val_i) begin
            pick = (rr_q == Prod0) ? Prod1 : Prod0;
        end else begin
            pick = wr1_val_i ? Prod1 : Prod0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (wr_fire) begin
            rr_d = pick;
        end
    end

    // Reset to "last granted = 1" so producer 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q <= Prod1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign full     = (rf_cnt_q == FullCnt);
    assign pick_val = (pick == Prod1) ? wr1_val_i : wr0_val_i;
    assign pop      = rd_val_o & rd_rdy_i;
    assign inflight = {1'b0, skid_cnt} + {2'b00, pend_q};

    // Handshake and RF port control, combinational from state and current valids.
    always_comb begin
        wr0_rdy_o  = (pick == Prod0) && !full && !flush_i;
        wr1_rdy_o  = (pick == Prod1) && !full && !flush_i;
        wr_fire    = pick_val && !full && !flush_i;
        // Issue only if the returning word still fits in the skid after this cycle's pop.
        rd_issue   = (rf_cnt_q != '0) && (inflight < (3'd2 + {2'b00, pop})) && !flush_i;

        rf_cena_o  = rf_en(rd_issue);
        rf_addra_o = rd_ptr_q;
        rf_cenb_o  = rf_en(wr_fire);
        rf_wenb_o  = rf_en(wr_fire);
        rf_addrb_o = wr_ptr_q;
        rf_datab_o = (pick == Prod1) ? wr1_dat_i : wr0_dat_i;
    end

    assign skid_push = pend_q && !flush_i;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(wr_fire);
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(rd_issue);
        rf_cnt_d     = rf_cnt_q + (ADDR_WIDTH + 1)'(wr_fire) - (ADDR_WIDTH + 1)'(rd_issue);
        pend_d       = rd_issue;
        skid_cnt_nxt = {1'b0, skid_cnt} + {2'b00, skid_push} - {2'b00, pop};
        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            rf_cnt_d     = '0;
            pend_d       = 1'b0;
            skid_cnt_nxt = 3'd0;
        end
        cnt_d = rf_cnt_d + (ADDR_WIDTH + 1)'(pend_d) + (ADDR_WIDTH + 1)'(skid_cnt_nxt);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rf_cnt_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rf_cnt_q <= rf_cnt_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    rf_fifo_skid2 #(
        .Width (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (flush_i),
        .push     (skid_push),
        .push_dat (rf_dataa_i),
        .pop      (pop),
        .head     (rd_dat_o),
        .cnt      (skid_cnt)
    );

    assign rd_val_o = (skid_cnt != 2'd0);
    assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_rf_2p_23x64_fifo_ctrl.sv
// Bench for rf_2p_23x64_fifo_ctrl with a behavioural RF alongside it; a queue model
// of accepted-but-unconsumed words is checked by a negedge monitor.
module tb_rf_2p_23x64_fifo_ctrl;
    import rf_2p_23x64_fifo_ctrl_pkg::*;

    localparam int unsigned DW = RfDataWidth;
    localparam int unsigned AW = RfAddrWidth;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush_i = 1'b0;
    logic          wr0_val = 1'b0, wr1_val = 1'b0;
    logic [DW-1:0] wr0_dat = '0, wr1_dat = '0;
    logic          wr0_rdy_o, wr1_rdy_o;
    logic          rd_val_o;
    logic [DW-1:0] rd_dat_o;
    logic          rd_rdy = 1'b0;
    logic [AW:0]   cnt_o;
    logic          rf_cena_o, rf_cenb_o, rf_wenb_o;
    logic [AW-1:0] rf_addra_o, rf_addrb_o;
    logic [DW-1:0] rf_dataa, rf_datab_o;

    logic [DW-1:0] rf_mem [RfDepth];

    always #5 clk = ~clk;

    rf_2p_23x64_fifo_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush_i),
        .wr0_val_i  (wr0_val),
        .wr0_dat_i  (wr0_dat),
        .wr1_val_i  (wr1_val),
        .wr1_dat_i  (wr1_dat),
        .wr0_rdy_o  (wr0_rdy_o),
        .wr1_rdy_o  (wr1_rdy_o),
        .rd_val_o   (rd_val_o),
        .rd_dat_o   (rd_dat_o),
        .rd_rdy_i   (rd_rdy),
        .cnt_o      (cnt_o),
        .rf_cena_o  (rf_cena_o),
        .rf_addra_o (rf_addra_o),
        .rf_dataa_i (rf_dataa),
        .rf_cenb_o  (rf_cenb_o),
        .rf_wenb_o  (rf_wenb_o),
        .rf_addrb_o (rf_addrb_o),
        .rf_datab_o (rf_datab_o)
    );

    // Behavioural two-port RF: synchronous write on B, one-cycle read on A.
    always @(posedge clk) begin
        if (!rf_cenb_o && !rf_wenb_o) rf_mem[rf_addrb_o] <= rf_datab_o;
        if (!rf_cena_o) rf_dataa <= rf_mem[rf_addra_o];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = -1;
    int t_val = -1;
    int n, k0, k1;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] outq[$];
    bit            last_g = 1'b1;
    bit            fire0_s, fire1_s, pop_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: model is the ordered list of words accepted but not yet consumed.
    always @(negedge clk) begin
        bit g;
        fire0_s = 1'b0;
        fire1_s = 1'b0;
        pop_s   = 1'b0;
        if (!rstn) begin
            mq.delete();
            last_g = 1'b1;
        end else begin
            chk("cnt_model", 32'(cnt_o), 32'(mq.size()));
            if (mq.size() == 0) chk("val_when_empty", 32'(rd_val_o), 32'd0);
            if (flush_i) begin
                chk("rdy0_flush", 32'(wr0_rdy_o), 32'd0);
                chk("rdy1_flush", 32'(wr1_rdy_o), 32'd0);
                mq.delete();
            end else begin
`ifdef RF_FIFO_FIXED_PRIO_EN
                g = (wr0_val || !wr1_val) ? 1'b0 : 1'b1;
`else
                g = (wr0_val && wr1_val) ? !last_g : (wr1_val && !wr0_val);
`endif
                if (mq.size() < 64) begin
                    if (wr0_val) chk("rdy0_grant", 32'(wr0_rdy_o), 32'(g == 1'b0));
                    if (wr1_val) chk("rdy1_grant", 32'(wr1_rdy_o), 32'(g == 1'b1));
                end
                if (rd_val_o && rd_rdy) begin
                    pop_s = 1'b1;
                    if (mq.size() == 0) begin
                        chk("pop_nonempty", 32'(mq.size()), 32'd1);
                    end else begin
                        chk("rd_dat", 32'(rd_dat_o), 32'(mq[0]));
                        void'(mq.pop_front());
                    end
                    outq.push_back(rd_dat_o);
                end
                fire0_s = wr0_val && wr0_rdy_o;
                fire1_s = wr1_val && wr1_rdy_o;
                if (fire0_s && fire1_s) chk("single_grant", 32'd2, 32'd1);
                if (fire0_s) begin
                    mq.push_back(wr0_dat);
                    last_g = 1'b0;
                end else if (fire1_s) begin
                    mq.push_back(wr1_dat);
                    last_g = 1'b1;
                end
                if (t_acc < 0 && (fire0_s || fire1_s)) t_acc = cyc;
                if (t_val < 0 && t_acc >= 0 && rd_val_o) t_val = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, sampled while reset is held.
        #12;
        chk("rst_rd_val", 32'(rd_val_o), 32'd0);
        chk("rst_rd_dat", 32'(rd_dat_o), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_cena", 32'(rf_cena_o), 32'd1);
        chk("rst_cenb", 32'(rf_cenb_o), 32'd1);
        chk("rst_wenb", 32'(rf_wenb_o), 32'd1);
        chk("rst_addra", 32'(rf_addra_o), 32'd0);
        chk("rst_addrb", 32'(rf_addrb_o), 32'd0);
        chk("rst_rdy0", 32'(wr0_rdy_o), 32'd1);
        chk("rst_rdy1", 32'(wr1_rdy_o), 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;

        // Producer 0 writes 1..5 back to back, consumer always ready.
        tick();
        outq.delete();
        t_acc = -1;
        t_val = -1;
        n = 0;
        k0 = 0;
        rd_rdy = 1'b1;
        wr0_val = 1'b1;
        wr0_dat = DW'(1);
        while (n < 5 && k0 < 30) begin
            tick();
            k0++;
            if (fire0_s) begin
                n++;
                wr0_dat = DW'(n + 1);
            end
            if (n == 5) wr0_val = 1'b0;
        end
        chk("seq_cycles", 32'(k0), 32'd5);
        repeat (10) tick();
        chk("first_latency", 32'(t_val - t_acc), 32'd3);
        chk("seq_len", 32'(outq.size()), 32'd5);
        for (int i = 0; i < outq.size(); i++) chk("seq_word", 32'(outq[i]), 32'(i + 1));
        chk("seq_cnt_zero", 32'(cnt_o), 32'd0);

        // Both producers valid continuously.
        outq.delete();
        k0 = 0;
        k1 = 0;
        wr0_val = 1'b1;
        wr1_val = 1'b1;
        wr0_dat = 23'h100000;
        wr1_dat = 23'h200000;
        repeat (16) begin
            tick();
            if (fire0_s) begin
                k0++;
                wr0_dat = 23'h100000 + DW'(k0);
            end
            if (fire1_s) begin
                k1++;
                wr1_dat = 23'h200000 + DW'(k1);
            end
        end
        wr0_val = 1'b0;
        wr1_val = 1'b0;
        repeat (10) tick();
        chk("arb_count", 32'(outq.size()), 32'd16);
`ifdef RF_FIFO_FIXED_PRIO_EN
        for (int i = 0; i < outq.size(); i++) chk("prio_src", 32'(outq[i][21:20]), 32'd1);
`else
        for (int i = 1; i < outq.size(); i++)
            chk("alt_src", 32'(outq[i][21:20]), (outq[i-1][21:20] == 2'b01) ? 32'd2 : 32'd1);
`endif

        // Full: consumer stalled, 64 in the RF plus 2 in the skid.
        rd_rdy = 1'b0;
        wr0_val = 1'b1;
        wr1_val = 1'b1;
        n = 0;
        repeat (90) begin
            wr0_dat = DW'($urandom);
            wr1_dat = DW'($urandom);
            tick();
            if (fire0_s || fire1_s) n++;
        end
        chk("full_accepts", 32'(n), 32'd66);
        chk("full_cnt", 32'(cnt_o), 32'd66);
        chk("full_rdy0", 32'(wr0_rdy_o), 32'd0);
        chk("full_rdy1", 32'(wr1_rdy_o), 32'd0);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        chk("full_one_pop", 32'(pop_s), 32'd1);
        n = 0;
        repeat (6) begin
            tick();
            if (fire0_s || fire1_s) n++;
        end
        chk("reopen_accepts", 32'(n), 32'd1);
        chk("reopen_cnt", 32'(cnt_o), 32'd66);
        wr0_val = 1'b0;
        wr1_val = 1'b0;
        rd_rdy = 1'b1;
        repeat (80) tick();
        chk("full_drain", 32'(cnt_o), 32'd0);

        // 70 words with continuous pop: pointers wrap past 63.
        n = 0;
        k0 = 0;
        while (n < 70 && k0 < 400) begin
            wr0_val = ($urandom_range(0, 3) != 0);
            wr1_val = ($urandom_range(0, 3) == 0);
            wr0_dat = DW'($urandom);
            wr1_dat = DW'($urandom);
            tick();
            k0++;
            if (fire0_s || fire1_s) n++;
        end
        chk("wrap_accepts", 32'(n >= 70), 32'd1);
        wr0_val = 1'b0;
        wr1_val = 1'b0;
        repeat (10) tick();
        chk("wrap_drain", 32'(cnt_o), 32'd0);

        // Flush with cnt_o=10 and a read in flight.
        rd_rdy = 1'b0;
        wr0_val = 1'b1;
        n = 0;
        k0 = 0;
        while (n < 10 && k0 < 40) begin
            wr0_dat = DW'($urandom);
            tick();
            k0++;
            if (fire0_s) n++;
        end
        wr0_val = 1'b0;
        repeat (5) tick();
        rd_rdy = 1'b1;
        wr0_val = 1'b1;
        wr0_dat = DW'($urandom);
        @(negedge clk);
        chk("pre_flush_issue", 32'(rf_cena_o), 32'd0);
        chk("pre_flush_wr", 32'(wr0_rdy_o), 32'd1);
        tick();
        rd_rdy = 1'b0;
        flush_i = 1'b1;
        wr0_dat = DW'($urandom);
        @(negedge clk);
        chk("flush_cnt_before", 32'(cnt_o), 32'd10);
        chk("flush_cena", 32'(rf_cena_o), 32'd1);
        chk("flush_cenb", 32'(rf_cenb_o), 32'd1);
        tick();
        flush_i = 1'b0;
        wr0_val = 1'b0;
        @(negedge clk);
        chk("flush_cnt_after", 32'(cnt_o), 32'd0);
        chk("flush_val_after", 32'(rd_val_o), 32'd0);
        repeat (4) tick();
        chk("flush_discard", 32'(cnt_o), 32'd0);

        // Randomised traffic with occasional flushes.
        repeat (1500) begin
            wr0_val = ($urandom_range(0, 3) != 0);
            wr1_val = ($urandom_range(0, 2) != 0);
            wr0_dat = DW'($urandom);
            wr1_dat = DW'($urandom);
            rd_rdy = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush_i = 1'b0;
        wr0_val = 1'b0;
        wr1_val = 1'b0;
        rd_rdy = 1'b1;
        repeat (80) tick();
        chk("rand_drain", 32'(cnt_o), 32'd0);

        // Asynchronous reset mid-stream.
        wr0_val = 1'b1;
        repeat (20) begin
            wr0_dat = DW'($urandom);
            tick();
        end
        #2;
        rstn = 1'b0;
        wr0_val = 1'b0;
        #1;
        chk("arst_rd_val", 32'(rd_val_o), 32'd0);
        chk("arst_rd_dat", 32'(rd_dat_o), 32'd0);
        chk("arst_cnt", 32'(cnt_o), 32'd0);
        chk("arst_cena", 32'(rf_cena_o), 32'd1);
        chk("arst_cenb", 32'(rf_cenb_o), 32'd1);
        chk("arst_addra", 32'(rf_addra_o), 32'd0);
        chk("arst_addrb", 32'(rf_addrb_o), 32'd0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        t_acc = -1;
        t_val = -1;
        wr0_val = 1'b1;
        wr0_dat = 23'h5a5a5;
        tick();
        wr0_val = 1'b0;
        repeat (8) tick();
        chk("arst_latency", 32'(t_val - t_acc), 32'd3);
        chk("arst_drain", 32'(cnt_o), 32'd0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_2p_23x64_fifo_ctrl.md
# rf_2p_23x64_fifo_ctrl

FIFO controller that sequences the 23x64 two-port register file (write on port B, read on port A) and shares its write port between two producers. It arbitrates the producers, owns the write and read pointers and occupancy, and issues RF reads ahead of demand. A 2-entry skid stage hides the RF's 1-cycle read latency, so a ready/valid consumer sees one word per cycle. It sits between producer stages of the encoder pipeline and the `top_rf_2p_23x64` instance, which is instantiated alongside it at the same level.

## Interface
- DATA_WIDTH, 23, word width; matches the RF.
- ADDR_WIDTH, 6, RF address width; depth = 2^ADDR_WIDTH = 64.
- clk  in  1  single clock; also drives clka/clkb of the RF.
- rstn  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all FIFO state.
- wr0_val_i / wr1_val_i  in  1  producer 0/1 word valid.
- wr0_dat_i / wr1_dat_i  in  DATA_WIDTH  producer 0/1 data.
- wr0_rdy_o / wr1_rdy_o  out  1  producer 0/1 accept; transfer on val&rdy.
- rd_val_o  out  1  output word valid.
- rd_dat_o  out  DATA_WIDTH  output word.
- rd_rdy_i  in  1  consumer accept.
- cnt_o  out  ADDR_WIDTH+1  words held: RF + in-flight read + skid.
- rf_cena_o  out  1  RF port A enable, active low.
- rf_addra_o  out  ADDR_WIDTH  RF read address.
- rf_dataa_i  in  DATA_WIDTH  RF read data, valid the cycle after rf_cena_o low.
- rf_cenb_o / rf_wenb_o  out  1  RF port B enable/write enable, active low.
- rf_addrb_o  out  ADDR_WIDTH  RF write address.
- rf_datab_o  out  DATA_WIDTH  RF write data.

## Operation
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap 63→0); rf_cnt (0..64); pend (read in flight); skid (2 entries, skid_cnt 0..2); rr (last-granted producer).
- Arbitration: at most one write per cycle.
  - Round robin: if both producers are valid, grant the one not in rr; otherwise grant the sole valid producer.
  - wrN_rdy_o = grantN & (rf_cnt != 64) & !flush_i. An ungranted producer sees rdy=0.
- Write fire: rf_cenb_o = rf_wenb_o = 0, rf_addrb_o = wr_ptr, rf_datab_o = granted data. Then wr_ptr++ and rr ← granted producer.
- Read issue condition: rf_cnt>0 and (skid_cnt + pend − pop) < 2, where pop = rd_val_o & rd_rdy_i. On issue: rf_cena_o = 0, rf_addra_o = rd_ptr, rd_ptr++, pend ← 1.
- When pend is set, the next cycle pushes rf_dataa_i into skid.
- rf_cnt += write fire − read issue. Simultaneous write and read issue leave rf_cnt unchanged.
- A read never targets the address being written in the same cycle, because it only consumes entries written in earlier cycles.
- rd_val_o = (skid_cnt>0); rd_dat_o = skid head.
- cnt_o = rf_cnt + pend + skid_cnt, registered.
- flush_i:
  - Clears pointers, rf_cnt, pend, skid and cnt_o at the next edge and leaves rr unchanged.
  - All rdy outputs are low; no RF access is issued.
  - Flush wins over any simultaneous write or pop. In-flight RF data is discarded.
- Full (rf_cnt == 64): both rdy outputs are 0. Reads continue, so one free slot reopens writes the next cycle.
- Empty: rd_val_o = 0 and RF port A stays idle (rf_cena_o = 1).

## Timing
- Reset values:
  - rd_val_o=0, rd_dat_o=0, cnt_o=0.
  - rf_cena_o=1, rf_cenb_o=1, rf_wenb_o=1, rf_addra_o=0, rf_addrb_o=0.
  - rr selects producer 0 first. Write ready is asserted with an idle (all-high) RF port B while full is 0.
- Reset mid-operation drops all stored words immediately (asynchronous).
- RF control outputs are combinational from registered state and current valids.
- First-word latency: write accepted in cycle N → read issued in N+1 → skid loaded at end of N+2 → rd_val_o=1 in cycle N+3.
- Sustained throughput is one write and one read per cycle with the consumer always ready.
- Once skid holds 2 words and pend is 0, stalling rd_rdy_i stops read issue with no data loss.

## Configuration
- RF_FIFO_FIXED_PRIO_EN: if defined, producer 0 has strict priority and rr is not implemented. If undefined, arbitration is round robin as above.

## Structure
- Shared package holds:
  - the RF geometry constants (23-bit word, 6-bit address, depth 64);
  - the active-low enable encoding constants.
- One sub-module, rf_fifo_skid2: the 2-entry output skid buffer with push, pop, head and count.

## Test plan
- Producer 0 writes 0x000001..0x000005 back to back, consumer always ready → wr0_rdy_o high throughout; rd_dat_o yields 1..5 in order; first rd_val_o exactly 3 cycles after the first accept; cnt_o returns to 0.
- Both producers valid continuously (A=0x1xxxxx, B=0x2xxxxx) → output alternates A, B, A, B, …; with RF_FIFO_FIXED_PRIO_EN defined, only A is accepted.
- Consumer stalled; write 66 words → 64 accepted into the RF plus 2 drained to skid; then both rdy go low and cnt_o=66. Releasing rd_rdy_i for one pop reopens one write the next cycle.
- Write 70 words with continuous pop → pointers wrap past 63; data order is preserved across the wrap.
- flush_i asserted with cnt_o=10 and a read in flight → next cycle cnt_o=0, rd_val_o=0; the write attempted in the flush cycle is not accepted.
- rstn pulsed low mid-stream → outputs take their reset values asynchronously; after release the first new word arrives with 3-cycle latency.
